imm_gen_pipe: RTL and testbench

Registered, handshaked immediate generator for the decode stage, parametrised for RV32 or RV64. It accepts one instruction word per cycle on a valid/ready input and decodes every base-ISA immediate format, sign- or zero-extended to XLEN. The decoded result, plus a format code and an illegal-opcode flag, is presented on a valid/ready output. A two-entry skid buffer gives full throughput under back-pressure. The block sits between fetch and the register-read/ALU operand mux.

---
 rtl/imm_gen_pkg.sv | 32 +++
 rtl/imm_gen_pipe_decode.sv | 85 ++++++++
 rtl/imm_gen_pipe.sv | 118 +++++++++++
 tb/tb_imm_gen_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and immediate format codes for the decode-stage immediate generator.
package imm_gen_pkg;

   localparam int unsigned INST_W = 32;
   localparam int unsigned OPC_W  = 7;

   localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_OP        = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_OP_32     = 7'b0111011;
   localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_SYSTEM    = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_NONE  = 3'd0,
      FMT_I     = 3'd1,
      FMT_S     = 3'd2,
      FMT_B     = 3'd3,
      FMT_U     = 3'd4,
      FMT_J     = 3'd5,
      FMT_SHAMT = 3'd6,
      FMT_Z     = 3'd7
   } imm_fmt_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational base-ISA immediate decoder (module imm_decode), XLEN = 32 or 64.
// IMMGEN_ZICSR_EN enables the CSR*I zero-extended uimm (fmt Z).
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [INST_W-1:0] inst,
   output logic [XLEN-1:0]   imm_c,
   output imm_fmt_e          fmt_c,
   output logic              illegal_c
);

   logic [OPC_W-1:0] opcode;
   logic [2:0]       funct3;
   logic             is_shift;
   logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_j, imm_u, shamt, shamt_w;

   assign opcode   = inst[6:0];
   assign funct3   = inst[14:12];
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

   // Sign-extending casts of each immediate layout
   assign imm_i   = XLEN'($signed(inst[31:20]));
   assign imm_s   = XLEN'($signed({inst[31:25], inst[11:7]}));
   assign imm_b   = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
   assign imm_j   = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
   assign imm_u   = XLEN'($signed({inst[31:12], 12'b0}));
   assign shamt   = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
   assign shamt_w = XLEN'(inst[24:20]);

   always_comb begin
      imm_c     = '0;
      fmt_c     = FMT_NONE;
      illegal_c = 1'b0;
      case (opcode)
         OPC_LOAD, OPC_JALR: begin
            imm_c = imm_i;
            fmt_c = FMT_I;
         end
         OPC_OP_IMM: begin
            imm_c = is_shift ? shamt : imm_i;
            fmt_c = is_shift ? FMT_SHAMT : FMT_I;
         end
         OPC_OP_IMM_32: begin
            if (XLEN == 64) begin
               imm_c = is_shift ? shamt_w : imm_i;
               fmt_c = is_shift ? FMT_SHAMT : FMT_I;
            end else begin
               illegal_c = 1'b1;
            end
         end
         OPC_STORE: begin
            imm_c = imm_s;
            fmt_c = FMT_S;
         end
         OPC_BRANCH: begin
            imm_c = imm_b;
            fmt_c = FMT_B;
         end
         OPC_JAL: begin
            imm_c = imm_j;
            fmt_c = FMT_J;
         end
         OPC_LUI, OPC_AUIPC: begin
            imm_c = imm_u;
            fmt_c = FMT_U;
         end
         OPC_OP, OPC_MISC_MEM: ;
         OPC_OP_32:
            illegal_c = (XLEN != 64);
         OPC_SYSTEM: begin
`ifdef IMMGEN_ZICSR_EN
            if (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111) begin
               imm_c = XLEN'(inst[19:15]);
               fmt_c = FMT_Z;
            end
`endif
         end
         default:
            illegal_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered valid/ready immediate generator with a two-entry skid buffer (M = output, S = skid).
// Optional IMMGEN_ZICSR_EN is handled inside imm_decode.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_imm,
   output imm_fmt_e          out_fmt,
   output logic              out_illegal,
   output logic [TAG_W-1:0]  out_tag
);

   logic [XLEN-1:0]  dec_imm;
   imm_fmt_e         dec_fmt;
   logic             dec_illegal;

   logic             s_valid;
   logic [XLEN-1:0]  s_imm;
   imm_fmt_e         s_fmt;
   logic             s_illegal;
   logic [TAG_W-1:0] s_tag;

   logic accept, drain;
   logic m_load_in, m_load_s, m_clear, s_load, s_clear, s_valid_nxt;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .inst      (in_inst),
      .imm_c     (dec_imm),
      .fmt_c     (dec_fmt),
      .illegal_c (dec_illegal)
   );

   assign accept = in_valid && in_ready;
   assign drain  = out_valid && out_ready;

   // Steering: S has priority into M; incoming goes to M if it is free or emptying
   always_comb begin
      m_load_in = 1'b0;
      m_load_s  = 1'b0;
      m_clear   = 1'b0;
      s_load    = 1'b0;
      s_clear   = 1'b0;
      if (drain) begin
         if (s_valid) begin
            m_load_s = 1'b1;
            s_clear  = 1'b1;
         end else if (accept) begin
            m_load_in = 1'b1;
         end else begin
            m_clear = 1'b1;
         end
      end else if (accept) begin
         if (!out_valid) m_load_in = 1'b1;
         else            s_load    = 1'b1;
      end
      s_valid_nxt = (s_valid && !s_clear) || s_load;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_valid  <= 1'b0;
         in_ready <= 1'b1;
      end else begin
         s_valid  <= s_valid_nxt;
         in_ready <= !s_valid_nxt;
      end
   end

   // Main register drives the outputs directly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_imm     <= '0;
         out_fmt     <= FMT_NONE;
         out_illegal <= 1'b0;
         out_tag     <= '0;
      end else if (m_load_s) begin
         out_valid   <= 1'b1;
         out_imm     <= s_imm;
         out_fmt     <= s_fmt;
         out_illegal <= s_illegal;
         out_tag     <= s_tag;
      end else if (m_load_in) begin
         out_valid   <= 1'b1;
         out_imm     <= dec_imm;
         out_fmt     <= dec_fmt;
         out_illegal <= dec_illegal;
         out_tag     <= in_tag;
      end else if (m_clear) begin
         out_valid   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_imm     <= '0;
         s_fmt     <= FMT_NONE;
         s_illegal <= 1'b0;
         s_tag     <= '0;
      end else if (s_load) begin
         s_imm     <= dec_imm;
         s_fmt     <= dec_fmt;
         s_illegal <= dec_illegal;
         s_tag     <= in_tag;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: RV32 and RV64 instances share one stimulus stream.
module tb_imm_gen_pipe;
   import imm_gen_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [31:0] in_tag;
   logic        out_ready;

   logic        in_ready32, out_valid32, out_illegal32;
   logic [31:0] out_imm32, out_tag32;
   imm_fmt_e    out_fmt32;
   logic        in_ready64, out_valid64, out_illegal64;
   logic [63:0] out_imm64;
   logic [31:0] out_tag64;
   imm_fmt_e    out_fmt64;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
      .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
      .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
      .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
      .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
   );

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] imm32;
      imm_fmt_e    fmt32;
      logic        ill32;
      logic [63:0] imm64;
      imm_fmt_e    fmt64;
      logic        ill64;
   } vec_t;

   localparam int unsigned NVEC = 18;
   vec_t vecs [NVEC];

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({in_ready32, out_valid32, out_imm32, out_fmt32, out_illegal32, out_tag32} !==
          {1'b1, 1'b0, 32'h0, FMT_NONE, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset32 got rdy=%b vld=%b imm=%h fmt=%0d ill=%b tag=%h want rdy=1 vld=0 rest 0",
                  in_ready32, out_valid32, out_imm32, out_fmt32, out_illegal32, out_tag32);
      end
      n_checks++;
      if ({in_ready64, out_valid64, out_imm64, out_fmt64, out_illegal64, out_tag64} !==
          {1'b1, 1'b0, 64'h0, FMT_NONE, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset64 got rdy=%b vld=%b imm=%h fmt=%0d ill=%b tag=%h want rdy=1 vld=0 rest 0",
                  in_ready64, out_valid64, out_imm64, out_fmt64, out_illegal64, out_tag64);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({in_ready32, out_valid32, in_ready64, out_valid64} !== 4'b1010) begin
         n_fail++;
         $display("FAIL reset_release got %b want 1010", {in_ready32, out_valid32, in_ready64, out_valid64});
      end
   endtask

   task automatic load_vectors();
      vecs[0]  = '{32'h12345037, 32'h12345000, FMT_U, 1'b0, 64'h0000_0000_1234_5000, FMT_U, 1'b0};
      vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, FMT_B, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, FMT_B, 1'b0};
      vecs[2]  = '{32'h43F0D093, 32'h0000001F, FMT_SHAMT, 1'b0, 64'h3F, FMT_SHAMT, 1'b0};
      vecs[3]  = '{32'h0000001B, 32'h0, FMT_NONE, 1'b1, 64'h0, FMT_I, 1'b0};
`ifdef IMMGEN_ZICSR_EN
      vecs[4]  = '{32'h3002D0F3, 32'h5, FMT_Z, 1'b0, 64'h5, FMT_Z, 1'b0};
`else
      vecs[4]  = '{32'h3002D0F3, 32'h0, FMT_NONE, 1'b0, 64'h0, FMT_NONE, 1'b0};
`endif
      vecs[5]  = '{32'h0000007F, 32'h0, FMT_NONE, 1'b1, 64'h0, FMT_NONE, 1'b1};
      vecs[6]  = '{32'hFFC12083, 32'hFFFFFFFC, FMT_I, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, FMT_I, 1'b0};
      vecs[7]  = '{32'hFE112C23, 32'hFFFFFFF8, FMT_S, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, FMT_S, 1'b0};
      vecs[8]  = '{32'h0080006F, 32'h8, FMT_J, 1'b0, 64'h8, FMT_J, 1'b0};
      vecs[9]  = '{32'hFFFFF097, 32'hFFFFF000, FMT_U, 1'b0, 64'hFFFF_FFFF_FFFF_F000, FMT_U, 1'b0};
      vecs[10] = '{32'h7FF00093, 32'h7FF, FMT_I, 1'b0, 64'h7FF, FMT_I, 1'b0};
      vecs[11] = '{32'h00000033, 32'h0, FMT_NONE, 1'b0, 64'h0, FMT_NONE, 1'b0};
      vecs[12] = '{32'h00000031, 32'h0, FMT_NONE, 1'b1, 64'h0, FMT_NONE, 1'b1};
      vecs[13] = '{32'h0000003B, 32'h0, FMT_NONE, 1'b1, 64'h0, FMT_NONE, 1'b0};
      vecs[14] = '{32'h02001093, 32'h0, FMT_SHAMT, 1'b0, 64'h20, FMT_SHAMT, 1'b0};
      vecs[15] = '{32'h03F0101B, 32'h0, FMT_NONE, 1'b1, 64'h1F, FMT_SHAMT, 1'b0};
      vecs[16] = '{32'h00000073, 32'h0, FMT_NONE, 1'b0, 64'h0, FMT_NONE, 1'b0};
      vecs[17] = '{32'h3002A0F3, 32'h0, FMT_NONE, 1'b0, 64'h0, FMT_NONE, 1'b0};
   endtask

   // Back-to-back stream with out_ready high: each result appears one cycle after its offer
   task automatic test_decode();
      vec_t v;
      out_ready = 1'b1;
      for (int i = 0; i <= int'(NVEC); i++) begin
         @(negedge clk);
         if (i > 0) begin
            v = vecs[i-1];
            n_checks++;
            if ({in_ready32, out_valid32, out_imm32, out_fmt32, out_illegal32, out_tag32} !==
                {1'b1, 1'b1, v.imm32, v.fmt32, v.ill32, 32'h8000_0000 + 32'(i-1)}) begin
               n_fail++;
               $display("FAIL decode32[%0d] inst=%h got rdy=%b vld=%b imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d ill=%b",
                        i-1, v.inst, in_ready32, out_valid32, out_imm32, out_fmt32, out_illegal32, out_tag32,
                        v.imm32, v.fmt32, v.ill32);
            end
            n_checks++;
            if ({in_ready64, out_valid64, out_imm64, out_fmt64, out_illegal64, out_tag64} !==
                {1'b1, 1'b1, v.imm64, v.fmt64, v.ill64, 32'h8000_0000 + 32'(i-1)}) begin
               n_fail++;
               $display("FAIL decode64[%0d] inst=%h got rdy=%b vld=%b imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d ill=%b",
                        i-1, v.inst, in_ready64, out_valid64, out_imm64, out_fmt64, out_illegal64, out_tag64,
                        v.imm64, v.fmt64, v.ill64);
            end
         end
         if (i < int'(NVEC)) begin
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            in_tag   = 32'h8000_0000 + 32'(i);
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      n_checks++;
      if ({out_valid32, out_valid64} !== 2'b00) begin
         n_fail++;
         $display("FAIL decode_drain got vld32=%b vld64=%b want 0 0", out_valid32, out_valid64);
      end
   endtask

   // Stall fills M and S, third offer is held, then a release drains 1,2,3 with no gap
   task automatic test_back_pressure();
      logic [31:0] insts [3];
      logic [31:0] exp32 [3];
      logic [63:0] exp64 [3];
      logic [2:0]  exp_rdy;
      logic [2:0]  exp_tag_idx;
      insts[0] = 32'h12345037; exp32[0] = 32'h12345000; exp64[0] = 64'h0000_0000_1234_5000;
      insts[1] = 32'hFE000EE3; exp32[1] = 32'hFFFFFFFC; exp64[1] = 64'hFFFF_FFFF_FFFF_FFFC;
      insts[2] = 32'h7FF00093; exp32[2] = 32'h7FF;      exp64[2] = 64'h7FF;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_inst = insts[0]; in_tag = 32'd1;
      // Per checkpoint: expected in_ready and index of the tag on the outputs
      exp_rdy = 3'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         case (k)
            0: begin exp_rdy[0] = 1'b1; exp_tag_idx = 3'd0; end
            1: begin exp_rdy[0] = 1'b0; exp_tag_idx = 3'd0; end
            2: begin exp_rdy[0] = 1'b0; exp_tag_idx = 3'd0; end
            3: begin exp_rdy[0] = 1'b1; exp_tag_idx = 3'd1; end
            default: begin exp_rdy[0] = 1'b1; exp_tag_idx = 3'd2; end
         endcase
         n_checks++;
         if ({in_ready32, out_valid32, out_imm32, out_tag32} !==
             {exp_rdy[0], 1'b1, exp32[exp_tag_idx], 32'(exp_tag_idx) + 32'd1}) begin
            n_fail++;
            $display("FAIL backpressure32 step%0d got rdy=%b vld=%b imm=%h tag=%0d want rdy=%b vld=1 imm=%h tag=%0d",
                     k, in_ready32, out_valid32, out_imm32, out_tag32, exp_rdy[0], exp32[exp_tag_idx], exp_tag_idx + 3'd1);
         end
         n_checks++;
         if ({in_ready64, out_valid64, out_imm64, out_tag64} !==
             {exp_rdy[0], 1'b1, exp64[exp_tag_idx], 32'(exp_tag_idx) + 32'd1}) begin
            n_fail++;
            $display("FAIL backpressure64 step%0d got rdy=%b vld=%b imm=%h tag=%0d want rdy=%b vld=1 imm=%h tag=%0d",
                     k, in_ready64, out_valid64, out_imm64, out_tag64, exp_rdy[0], exp64[exp_tag_idx], exp_tag_idx + 3'd1);
         end
         case (k)
            0: begin in_inst = insts[1]; in_tag = 32'd2; end
            1: begin in_inst = insts[2]; in_tag = 32'd3; end
            2: out_ready = 1'b1;
            4: in_valid = 1'b0;
            default: ;
         endcase
      end
      @(negedge clk);
      n_checks++;
      if ({out_valid32, out_valid64, in_ready32, in_ready64} !== 4'b0011) begin
         n_fail++;
         $display("FAIL backpressure_end got %b want 0011", {out_valid32, out_valid64, in_ready32, in_ready64});
      end
   endtask

   // Asynchronous reset with both entries full, then a fresh instruction with latency 1
   task automatic test_reset_mid();
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_inst = 32'h12345037; in_tag = 32'hA;
      @(negedge clk);
      in_inst = 32'hFE000EE3; in_tag = 32'hB;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if ({in_ready32, out_valid32, in_ready64, out_valid64} !== 4'b0101) begin
         n_fail++;
         $display("FAIL reset_mid_full got %b want 0101", {in_ready32, out_valid32, in_ready64, out_valid64});
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready32, out_valid32, out_imm32, out_fmt32, out_illegal32, out_tag32} !==
          {1'b1, 1'b0, 32'h0, FMT_NONE, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_mid32 got rdy=%b vld=%b imm=%h fmt=%0d ill=%b tag=%h want rdy=1 vld=0 rest 0",
                  in_ready32, out_valid32, out_imm32, out_fmt32, out_illegal32, out_tag32);
      end
      n_checks++;
      if ({in_ready64, out_valid64, out_imm64, out_tag64} !== {1'b1, 1'b0, 64'h0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_mid64 got rdy=%b vld=%b imm=%h tag=%h want rdy=1 vld=0 imm=0 tag=0",
                  in_ready64, out_valid64, out_imm64, out_tag64);
      end
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      in_valid = 1'b1; in_inst = 32'h7FF00093; in_tag = 32'hC;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid32, out_imm32, out_fmt32, out_tag32, out_valid64, out_imm64, out_tag64} !==
          {1'b1, 32'h7FF, FMT_I, 32'hC, 1'b1, 64'h7FF, 32'hC}) begin
         n_fail++;
         $display("FAIL reset_mid_restart got vld=%b imm=%h fmt=%0d tag=%h vld64=%b imm64=%h tag64=%h want 1 7ff I c",
                  out_valid32, out_imm32, out_fmt32, out_tag32, out_valid64, out_imm64, out_tag64);
      end
      @(negedge clk);
      n_checks++;
      if ({out_valid32, out_valid64} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_mid_drain got %b want 00", {out_valid32, out_valid64});
      end
   endtask

   initial begin
      load_vectors();
      test_reset();
      test_decode();
      test_back_pressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
